// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL reset supervisor.
package pll_sup_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } state_t;

  typedef struct packed {
    logic pll_rst;
    logic sys_nrst;
    logic pll_ok;
    logic fault;
  } sup_out_t;

  localparam sup_out_t SUP_OUT_RST = '{pll_rst: 1'b1, sys_nrst: 1'b0, pll_ok: 1'b0, fault: 1'b0};

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output decode of a state; the top registers this on the next state.
  function automatic sup_out_t decode(input state_t s);
    sup_out_t o;
    o = '0;
    case (s)
      RESET_PLL: o.pll_rst = 1'b1;
      RUN: begin
        o.sys_nrst = 1'b1;
        o.pll_ok   = 1'b1;
      end
      FAULT: begin
        o.pll_rst = 1'b1;
        o.fault   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_pipe;

  // Shift the async input through two flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sync_pipe <= '0;
    else       sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/pll_reset_supervisor.sv
// PLL reset supervisor: pulses the PLL reset, waits for a stable lock,
// then releases the system reset. Runs on the reference clock.
// Macro PLL_RETRY_EN: when defined, timeouts and lock loss re-pulse the PLL
// up to MAX_RETRIES times before FAULT; when undefined, a timeout goes
// straight to FAULT and lock loss in RUN just waits for relock.
module pll_reset_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               pll_locked_async,
  output logic               pll_rst,
  output logic               sys_nrst,
  output logic               pll_ok,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_MAX = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES), LOCK_STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic             lk;
  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry;
  logic             retry_req;
  sup_out_t         outs;

  sync_2ff u_lock_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (pll_locked_async),
    .q    (lk)
  );

`ifdef PLL_RETRY_EN
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  logic [RETRY_W-1:0] retry_nxt;
`endif

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    nxt_state = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_req = 1'b0;
`ifdef PLL_RETRY_EN
    retry_nxt = retry;
`endif
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          nxt_state = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        // lock beats a coincident timeout
        if (lk) begin
          nxt_state = STABILIZE;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          retry_req = 1'b1;
        end
      end
      STABILIZE: begin
        // a dropout restarts the lock wait; it is not a retry
        if (!lk) begin
          nxt_state = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == ST_LAST) begin
          nxt_state = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!lk) begin
`ifdef PLL_RETRY_EN
          retry_req = 1'b1;
`else
          nxt_state = WAIT_LOCK;
`endif
        end
      end
      FAULT: cnt_nxt = '0;
      default: begin
        nxt_state = RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase

    if (retry_req) begin
      cnt_nxt = '0;
`ifdef PLL_RETRY_EN
      if (retry < RETRY_MAX) begin
        retry_nxt = retry + RETRY_W'(1);
        nxt_state = RESET_PLL;
      end else begin
        nxt_state = FAULT;
      end
`else
      nxt_state = FAULT;
`endif
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= RESET_PLL;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PLL_RETRY_EN
  // Retry count since nrst; never passes MAX_RETRIES.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) retry <= '0;
    else       retry <= retry_nxt;
  end
`else
  assign retry = '0;
`endif

  // Outputs are registered on the next state so they move with the state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) outs <= SUP_OUT_RST;
    else       outs <= decode(nxt_state);
  end

  assign pll_rst     = outs.pll_rst;
  assign sys_nrst    = outs.sys_nrst;
  assign pll_ok      = outs.pll_ok;
  assign fault       = outs.fault;
  assign retry_count = retry;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor with a scoreboard queue.
// Output vector packing: {pll_rst, sys_nrst, pll_ok, fault, retry_count[3:0]}.
module tb_pll_reset_supervisor;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       pll_locked_async = 1'b0;
  logic       pll_rst, sys_nrst, pll_ok, fault;
  logic [3:0] retry_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  pll_reset_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (100),
    .LOCK_STABLE_CYCLES  (16),
    .MAX_RETRIES         (2)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .pll_locked_async (pll_locked_async),
    .pll_rst          (pll_rst),
    .sys_nrst         (sys_nrst),
    .pll_ok           (pll_ok),
    .fault            (fault),
    .retry_count      (retry_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_cmp++;
    if (sb_exp.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0h expected an entry", obs);
      return;
    end
    tag = sb_tag.pop_front();
    exp = sb_exp.pop_front();
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outv();
    return {24'd0, pll_rst, sys_nrst, pll_ok, fault, retry_count};
  endfunction

  function automatic logic sig(input int w);
    case (w)
      0:       return sys_nrst;
      1:       return pll_rst;
      default: return fault;
    endcase
  endfunction

  // Tick until the chosen output reaches lvl; at = edge index or -1 on timeout.
  task automatic wait_for(input int which, input logic lvl, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sig(which) === lvl) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset(input string tag, output int c0);
    nrst = 1'b0;
    pll_locked_async = 1'b0;
    repeat (3) tick();
    push(tag, 32'h80);
    chk(outv());
    nrst = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    int c0, c, at, pulses, fault_at;
    logic prev;

    // T1: cold start, lock at t0+10 -> release at t0+28
    do_reset("reset_state", c0);
    for (int j = 0; j <= 4; j++) begin
      run_to(c0 + j);
      push($sformatf("t1_pll_rst_%0d", j), (j < 4) ? 32'd1 : 32'd0);
      chk({31'd0, pll_rst});
    end
    run_to(c0 + 9);
    pll_locked_async = 1'b1;
    push("t1_rise_cycle", c0 + 28);
    wait_for(0, 1'b1, 100, at);
    chk(at);
    push("t1_run_outputs", 32'h60);
    chk(outv());

    // T4: lock loss in RUN
    run_to(at + 5);
    c = cyc;
    pll_locked_async = 1'b0;
    push("t4_fall_cycle", c + 3);
    wait_for(0, 1'b0, 20, at);
    chk(at);
`ifdef PLL_RETRY_EN
    push("t4_after_fall", 32'h81);
    chk(outv());
    push("t4_pulse_end", c + 7);
    wait_for(1, 1'b0, 20, at);
    chk(at);
`else
    push("t4_after_fall", 32'h00);
    chk(outv());
`endif
    run_to(c + 10);
    pll_locked_async = 1'b1;
    push("t4_rerise_cycle", c + 29);
    wait_for(0, 1'b1, 100, at);
    chk(at);
`ifdef PLL_RETRY_EN
    push("t4_rerun_outputs", 32'h61);
`else
    push("t4_rerun_outputs", 32'h60);
`endif
    chk(outv());

    // T5: second lock loss, then nrst low during STABILIZE
    run_to(at + 3);
    c = cyc;
    pll_locked_async = 1'b0;
    push("t5_fall_cycle", c + 3);
    wait_for(0, 1'b0, 20, at);
    chk(at);
    run_to(c + 10);
    pll_locked_async = 1'b1;
    run_to(c + 18);
`ifdef PLL_RETRY_EN
    push("t5_stabilize", 32'h02);
`else
    push("t5_stabilize", 32'h00);
`endif
    chk(outv());
    nrst = 1'b0;
    #1;
    push("t5_async_reset", 32'h80);
    chk(outv());

    // T2: one-cycle dropout after 8 stable cycles
    do_reset("t2_reset_state", c0);
    run_to(c0 + 9);
    pll_locked_async = 1'b1;
    run_to(c0 + 17);
    pll_locked_async = 1'b0;
    run_to(c0 + 18);
    pll_locked_async = 1'b1;
    push("t2_rise_cycle", c0 + 37);
    wait_for(0, 1'b1, 100, at);
    chk(at);
    push("t2_run_outputs", 32'h60);
    chk(outv());

    // T7: lock seen on the exact timeout cycle -> lock wins
    do_reset("t7_reset_state", c0);
    run_to(c0 + 101);
    pll_locked_async = 1'b1;
    push("t7_rise_cycle", c0 + 120);
    wait_for(0, 1'b1, 200, at);
    chk(at);
    push("t7_run_outputs", 32'h60);
    chk(outv());

    // T3/T6: lock never arrives
    do_reset("t3_reset_state", c0);
    pulses = 1;
    fault_at = -1;
    prev = pll_rst;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (pll_rst && !prev && !fault) pulses++;
      prev = pll_rst;
      if (fault && fault_at < 0) fault_at = cyc;
    end
`ifdef PLL_RETRY_EN
    push("t3_fault_cycle", c0 + 312);
    push("t3_pulses", 32'd3);
    push("t3_fault_outputs", 32'h92);
`else
    push("t3_fault_cycle", c0 + 104);
    push("t3_pulses", 32'd1);
    push("t3_fault_outputs", 32'h90);
`endif
    chk(fault_at);
    chk(pulses);
    chk(outv());
    pll_locked_async = 1'b1;
    repeat (40) tick();
`ifdef PLL_RETRY_EN
    push("t3_fault_sticky", 32'h92);
`else
    push("t3_fault_sticky", 32'h90);
`endif
    chk(outv());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
